// File: rtl/uart_i2c_usb_spi_arb_if.sv
// Register-bus bundle between the two requesters, the arbiter and the peripheral block.
// Handshake: a requester holds mX_reg_cs until a one-cycle mX_reg_ack or mX_reg_err; the arbiter holds s_reg_cs until s_reg_ack or timeout.
interface uart_i2c_usb_spi_arb_if;
  logic        m0_reg_cs;
  logic        m0_reg_wr;
  logic [7:0]  m0_reg_addr;
  logic [31:0] m0_reg_wdata;
  logic [3:0]  m0_reg_be;
  logic [31:0] m0_reg_rdata;
  logic        m0_reg_ack;
  logic        m0_reg_err;

  logic        m1_reg_cs;
  logic        m1_reg_wr;
  logic [7:0]  m1_reg_addr;
  logic [31:0] m1_reg_wdata;
  logic [3:0]  m1_reg_be;
  logic [31:0] m1_reg_rdata;
  logic        m1_reg_ack;
  logic        m1_reg_err;

  logic        s_reg_cs;
  logic        s_reg_wr;
  logic [7:0]  s_reg_addr;
  logic [31:0] s_reg_wdata;
  logic [3:0]  s_reg_be;
  logic [31:0] s_reg_rdata;
  logic        s_reg_ack;

  // Arbiter side
  modport master (
    input  m0_reg_cs, m0_reg_wr, m0_reg_addr, m0_reg_wdata, m0_reg_be,
    output m0_reg_rdata, m0_reg_ack, m0_reg_err,
    input  m1_reg_cs, m1_reg_wr, m1_reg_addr, m1_reg_wdata, m1_reg_be,
    output m1_reg_rdata, m1_reg_ack, m1_reg_err,
    output s_reg_cs, s_reg_wr, s_reg_addr, s_reg_wdata, s_reg_be,
    input  s_reg_rdata, s_reg_ack
  );

  // Requester/peripheral side
  modport slave (
    output m0_reg_cs, m0_reg_wr, m0_reg_addr, m0_reg_wdata, m0_reg_be,
    input  m0_reg_rdata, m0_reg_ack, m0_reg_err,
    output m1_reg_cs, m1_reg_wr, m1_reg_addr, m1_reg_wdata, m1_reg_be,
    input  m1_reg_rdata, m1_reg_ack, m1_reg_err,
    input  s_reg_cs, s_reg_wr, s_reg_addr, s_reg_wdata, s_reg_be,
    output s_reg_rdata, s_reg_ack
  );
endinterface

// File: rtl/uart_i2c_usb_spi_arb.sv
// Round-robin two-requester arbiter for the UART/I2C/USB/SPI register bus,
// with a watchdog that turns a missing peripheral ack into an error response.
module uart_i2c_usb_spi_arb #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                          app_clk,
  input  logic                          reset_n,
  uart_i2c_usb_spi_arb_if.master        bus,
  output logic                          arb_busy,
  output logic                          arb_gnt,
  output logic [1:0]                    dbg_state_o
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_e;

  state_e             state_q, state_d;
  logic               ptr_q, ptr_d;
  logic               gnt_q, gnt_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               s_cs_q, s_cs_d;
  logic               s_wr_q, s_wr_d;
  logic [7:0]         s_addr_q, s_addr_d;
  logic [31:0]        s_wdata_q, s_wdata_d;
  logic [3:0]         s_be_q, s_be_d;
  logic [1:0][31:0]   rdata_q, rdata_d;
  logic [1:0]         ack_q, ack_d;
  logic [1:0]         err_q, err_d;
  logic [1:0]         req;
  logic               win;

  assign req = {bus.m1_reg_cs, bus.m0_reg_cs};
  // On a tie the requester that did not win last time is served.
  assign win = (req == 2'b11) ? ~ptr_q : req[1];

  always_ff @(posedge app_clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      ptr_q     <= 1'b1;
      gnt_q     <= 1'b0;
      cnt_q     <= '0;
      s_cs_q    <= 1'b0;
      s_wr_q    <= 1'b0;
      s_addr_q  <= '0;
      s_wdata_q <= '0;
      s_be_q    <= '0;
      rdata_q   <= '0;
      ack_q     <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      cnt_q     <= cnt_d;
      s_cs_q    <= s_cs_d;
      s_wr_q    <= s_wr_d;
      s_addr_q  <= s_addr_d;
      s_wdata_q <= s_wdata_d;
      s_be_q    <= s_be_d;
      rdata_q   <= rdata_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    cnt_d     = cnt_q;
    s_cs_d    = s_cs_q;
    s_wr_d    = s_wr_q;
    s_addr_d  = s_addr_q;
    s_wdata_d = s_wdata_q;
    s_be_d    = s_be_q;
    rdata_d   = rdata_q;
    ack_d     = 2'b00;
    err_d     = 2'b00;
    unique case (state_q)
      IDLE: begin
        if (req != 2'b00) begin
          ptr_d     = win;
          gnt_d     = win;
          cnt_d     = '0;
          s_cs_d    = 1'b1;
          s_wr_d    = win ? bus.m1_reg_wr    : bus.m0_reg_wr;
          s_addr_d  = win ? bus.m1_reg_addr  : bus.m0_reg_addr;
          s_wdata_d = win ? bus.m1_reg_wdata : bus.m0_reg_wdata;
          s_be_d    = win ? bus.m1_reg_be    : bus.m0_reg_be;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        // Ack takes priority over a timeout landing on the same edge.
        if (bus.s_reg_ack) begin
          s_cs_d         = 1'b0;
          rdata_d[gnt_q] = bus.s_reg_rdata;
          ack_d[gnt_q]   = 1'b1;
          state_d        = DONE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          s_cs_d         = 1'b0;
          rdata_d[gnt_q] = 32'hFFFF_FFFF;
          err_d[gnt_q]   = 1'b1;
          state_d        = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.s_reg_cs     = s_cs_q;
  assign bus.s_reg_wr     = s_wr_q;
  assign bus.s_reg_addr   = s_addr_q;
  assign bus.s_reg_wdata  = s_wdata_q;
  assign bus.s_reg_be     = s_be_q;
  assign bus.m0_reg_rdata = rdata_q[0];
  assign bus.m0_reg_ack   = ack_q[0];
  assign bus.m0_reg_err   = err_q[0];
  assign bus.m1_reg_rdata = rdata_q[1];
  assign bus.m1_reg_ack   = ack_q[1];
  assign bus.m1_reg_err   = err_q[1];
  assign arb_busy         = (state_q == BUSY) || (state_q == DONE);
  assign arb_gnt          = gnt_q;
  assign dbg_state_o      = state_q;
endmodule
